axil_read_arbiter: RTL and testbench

Round-robin arbiter that shares one AXI-Lite read slave (ARADDR/ARVALID/ARREADY, RDATA/RVALID/RREADY) between NUM_REQ on-chip requesters. Each requester presents a simple valid/address request and receives a one-cycle response pulse. The block sequences one outstanding read at a time through the slave's address and data channels, with a timeout guard. It sits between the requester fabric and the AXI-Lite read slave on the single ACLK domain.

---
 rtl/axil_read_arbiter_pkg.sv | 19 +
 rtl/axil_read_arbiter_if.sv | 37 +++
 rtl/axil_read_arbiter_rr_pick.sv | 27 ++
 rtl/axil_read_arbiter.sv | 139 +++++++++++++
 tb/tb_axil_read_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_read_arbiter_pkg.sv
// Shared definitions for the AXI-Lite read arbiter: FSM encoding, the data
// value returned with a timeout error, and a small index-wrapping helper.
package axil_read_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  localparam int unsigned TIMEOUT_ERR_DATA = 0;
  localparam int CNT_W = 16;

  // Next index after cur, wrapping at n.
  function automatic int wrap_inc(input int cur, input int n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/axil_read_arbiter_if.sv
// Requester-side and AXI-Lite read-slave-side signals of the arbiter.
// Handshakes: a transfer happens on a rising ACLK edge where valid and ready
// are both high; REQ_VALID/M_ARVALID hold with stable payload until then.
interface axil_read_arbiter_if #(
  parameter int REG_WIDTH = 32,
  parameter int NUM_REQ   = 4
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           REQ_VALID;
  logic [NUM_REQ*REG_WIDTH-1:0] REQ_ADDR;
  logic [NUM_REQ-1:0]           REQ_READY;
  logic [NUM_REQ-1:0]           RSP_VALID;
  logic [REG_WIDTH-1:0]         RSP_DATA;
  logic                         RSP_ERR;
  logic [IDX_W-1:0]             GRANT_ID;
  logic                         BUSY;
  logic [REG_WIDTH-1:0]         M_ARADDR;
  logic                         M_ARVALID;
  logic                         M_ARREADY;
  logic [REG_WIDTH-1:0]         M_RDATA;
  logic                         M_RVALID;
  logic                         M_RREADY;

  modport master (
    input  REQ_VALID, REQ_ADDR, M_ARREADY, M_RDATA, M_RVALID,
    output REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR, GRANT_ID, BUSY,
           M_ARADDR, M_ARVALID, M_RREADY
  );

  modport slave (
    output REQ_VALID, REQ_ADDR, M_ARREADY, M_RDATA, M_RVALID,
    input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR, GRANT_ID, BUSY,
           M_ARADDR, M_ARVALID, M_RREADY
  );

endinterface

// File: rtl/axil_read_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request bit found
// scanning upward from ptr, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);

  int idx;

  // Scan from the farthest offset down so the closest-to-ptr request wins.
  always_comb begin
    winner = '0;
    any    = |req;
    idx    = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[IDX_W'(idx)]) winner = IDX_W'(idx);
    end
  end

endmodule

// File: rtl/axil_read_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite read slave among NUM_REQ
// requesters, one outstanding read at a time, with a timeout abort.
module axil_read_arbiter
  import axil_read_arbiter_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  axil_read_arbiter_if.master  bus,
  output arb_state_t           state_dbg
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [REG_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic [REG_WIDTH-1:0] araddr_q, araddr_d;
  logic                 arvalid_q, arvalid_d;
  logic                 rready_q, rready_d;

  logic [IDX_W-1:0]     pick_winner;
  logic                 pick_any;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (bus.REQ_VALID),
    .ptr    (ptr_q),
    .winner (pick_winner),
    .any    (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          araddr_d                 = bus.REQ_ADDR[int'(pick_winner)*REG_WIDTH +: REG_WIDTH];
          arvalid_d                = 1'b1;
          rready_d                 = 1'b1;
          req_ready_d[pick_winner] = 1'b1;
          grant_d                  = pick_winner;
          cnt_d                    = '0;
          busy_d                   = 1'b1;
          state_d                  = ST_ADDR;
        end
      end
      ST_ADDR, ST_DATA: begin
        cnt_d = cnt_q + 1'b1;
        // R completion takes priority; it may arrive together with ARREADY.
        if (bus.M_RVALID && rready_q) begin
          rsp_data_d           = bus.M_RDATA;
          rsp_valid_d[grant_q] = 1'b1;
          arvalid_d            = 1'b0;
          rready_d             = 1'b0;
          busy_d               = 1'b0;
          ptr_d                = IDX_W'(wrap_inc(int'(grant_q), NUM_REQ));
          state_d              = ST_IDLE;
        end else if (cnt_q == TIMEOUT_CNT) begin
          rsp_data_d           = REG_WIDTH'(TIMEOUT_ERR_DATA);
          rsp_valid_d[grant_q] = 1'b1;
          rsp_err_d            = 1'b1;
          arvalid_d            = 1'b0;
          rready_d             = 1'b0;
          busy_d               = 1'b0;
          ptr_d                = IDX_W'(wrap_inc(int'(grant_q), NUM_REQ));
          state_d              = ST_IDLE;
        end else if (state_q == ST_ADDR && bus.M_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = ST_DATA;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
    end
  end

  assign bus.REQ_READY = req_ready_q;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_ERR   = rsp_err_q;
  assign bus.RSP_DATA  = rsp_data_q;
  assign bus.GRANT_ID  = grant_q;
  assign bus.BUSY      = busy_q;
  assign bus.M_ARADDR  = araddr_q;
  assign bus.M_ARVALID = arvalid_q;
  assign bus.M_RREADY  = rready_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_axil_read_arbiter.sv
// Directed bench for axil_read_arbiter: single read, fairness, wrap,
// timeout, simultaneous AR/R completion and reset during DATA.
module tb_axil_read_arbiter;
  import axil_read_arbiter_pkg::*;

  localparam int W  = 32;
  localparam int NR = 4;

  logic       clk;
  logic       rst_n;
  arb_state_t state_dbg;

  int n_chk  = 0;
  int n_fail = 0;
  int overlap_cnt = 0;
  int data_cycles = 0;
  int slv_mode  = 0;        // 0: AR+R next cycle, 1: stall, 2: AR only
  logic          slv_fixed = 1'b0;
  logic [W-1:0]  slv_fixed_data = '0;

  axil_read_arbiter_if #(.REG_WIDTH(W), .NUM_REQ(NR)) bus ();

  axil_read_arbiter #(.REG_WIDTH(W), .NUM_REQ(NR), .TIMEOUT(8)) dut (
    .ACLK      (clk),
    .ARESETN   (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // simple read slave
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.M_ARREADY <= 1'b0;
      bus.M_RVALID  <= 1'b0;
      bus.M_RDATA   <= '0;
    end else begin
      bus.M_ARREADY <= 1'b0;
      bus.M_RVALID  <= 1'b0;
      if (bus.M_ARVALID && !bus.M_ARREADY) begin
        if (slv_mode == 0 || slv_mode == 2) bus.M_ARREADY <= 1'b1;
        if (slv_mode == 0) begin
          bus.M_RVALID <= 1'b1;
          bus.M_RDATA  <= slv_fixed ? slv_fixed_data
                                    : (32'hA5A5_0000 | {16'h0, bus.M_ARADDR[15:0]});
        end
      end
    end
  end

  // monitors
  always @(negedge clk) begin
    if ((bus.REQ_READY & bus.RSP_VALID) != '0) overlap_cnt++;
    if (state_dbg == ST_DATA) data_cycles++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [W-1:0] a);
    bus.REQ_ADDR[i*W +: W] = a;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.REQ_READY), 64'h0);
    chk({tag, "_rsp_valid"}, 64'(bus.RSP_VALID), 64'h0);
    chk({tag, "_rsp_err"},   64'(bus.RSP_ERR),   64'h0);
    chk({tag, "_rsp_data"},  64'(bus.RSP_DATA),  64'h0);
    chk({tag, "_grant"},     64'(bus.GRANT_ID),  64'h0);
    chk({tag, "_busy"},      64'(bus.BUSY),      64'h0);
    chk({tag, "_araddr"},    64'(bus.M_ARADDR),  64'h0);
    chk({tag, "_arvalid"},   64'(bus.M_ARVALID), 64'h0);
    chk({tag, "_rready"},    64'(bus.M_RREADY),  64'h0);
    chk({tag, "_state"},     64'(state_dbg),     64'(ST_IDLE));
  endtask

  int g;
  int dc0;

  initial begin
    rst_n         = 1'b0;
    bus.REQ_VALID = '0;
    bus.REQ_ADDR  = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // single read: requester 1, address 5
    set_addr(1, 32'd5);
    bus.REQ_VALID = 4'b0010;
    tick();
    chk("single_req_ready", 64'(bus.REQ_READY), 64'h2);
    chk("single_arvalid",   64'(bus.M_ARVALID), 64'h1);
    chk("single_araddr",    64'(bus.M_ARADDR),  64'h5);
    chk("single_grant",     64'(bus.GRANT_ID),  64'h1);
    chk("single_busy",      64'(bus.BUSY),      64'h1);
    bus.REQ_VALID = '0;
    tick();
    chk("single_ready_pulse", 64'(bus.REQ_READY), 64'h0);
    chk("single_no_rsp_yet",  64'(bus.RSP_VALID), 64'h0);
    tick();
    chk("single_rsp_valid", 64'(bus.RSP_VALID), 64'h2);
    chk("single_rsp_data",  64'(bus.RSP_DATA),  64'hA5A5_0005);
    chk("single_rsp_err",   64'(bus.RSP_ERR),   64'h0);
    chk("single_idle",      64'(state_dbg),     64'(ST_IDLE));
    tick();
    chk("single_rsp_pulse", 64'(bus.RSP_VALID), 64'h0);

    // fairness: fresh reset so scanning starts at requester 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) set_addr(i, W'(32'h10 + i * 4));
    bus.REQ_VALID = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      g = i % NR;
      tick();
      chk($sformatf("fair_grant_%0d", i), 64'(bus.GRANT_ID),  64'(g));
      chk($sformatf("fair_ready_%0d", i), 64'(bus.REQ_READY), 64'(1 << g));
      tick();
      tick();
      chk($sformatf("fair_rsp_%0d", i),  64'(bus.RSP_VALID), 64'(1 << g));
      chk($sformatf("fair_data_%0d", i), 64'(bus.RSP_DATA),  64'(32'hA5A5_0010 + g * 4));
    end
    bus.REQ_VALID = '0;
    tick();

    // wrap: grant 2 alone, then 0 and 2 together -> 0 first, then 2
    set_addr(0, 32'h40);
    set_addr(2, 32'h48);
    bus.REQ_VALID = 4'b0100;
    tick();
    chk("wrap_first_grant", 64'(bus.GRANT_ID), 64'h2);
    bus.REQ_VALID = '0;
    tick();
    tick();
    chk("wrap_first_rsp", 64'(bus.RSP_VALID), 64'h4);
    bus.REQ_VALID = 4'b0101;
    tick();
    chk("wrap_grant0",   64'(bus.GRANT_ID),  64'h0);
    chk("wrap_ready0",   64'(bus.REQ_READY), 64'h1);
    bus.REQ_VALID = 4'b0100;
    tick();
    tick();
    chk("wrap_rsp0",     64'(bus.RSP_VALID), 64'h1);
    chk("wrap_data0",    64'(bus.RSP_DATA),  64'hA5A5_0040);
    tick();
    chk("wrap_grant2",   64'(bus.GRANT_ID),  64'h2);
    chk("wrap_ready2",   64'(bus.REQ_READY), 64'h4);
    bus.REQ_VALID = '0;
    tick();
    tick();
    chk("wrap_rsp2",     64'(bus.RSP_VALID), 64'h4);
    chk("wrap_data2",    64'(bus.RSP_DATA),  64'hA5A5_0048);

    // timeout: slave never answers, TIMEOUT = 8 (ptr now 3 -> grant 0)
    slv_mode = 1;
    set_addr(0, 32'h30);
    bus.REQ_VALID = 4'b0001;
    tick();
    chk("to_arvalid", 64'(bus.M_ARVALID), 64'h1);
    chk("to_grant",   64'(bus.GRANT_ID),  64'h0);
    bus.REQ_VALID = '0;
    repeat (8) tick();
    chk("to_no_rsp_early", 64'(bus.RSP_VALID), 64'h0);
    chk("to_busy_early",   64'(bus.BUSY),      64'h1);
    tick();
    chk("to_rsp_valid", 64'(bus.RSP_VALID), 64'h1);
    chk("to_rsp_err",   64'(bus.RSP_ERR),   64'h1);
    chk("to_rsp_data",  64'(bus.RSP_DATA),  64'h0);
    chk("to_arvalid_0", 64'(bus.M_ARVALID), 64'h0);
    chk("to_rready_0",  64'(bus.M_RREADY),  64'h0);
    chk("to_idle",      64'(state_dbg),     64'(ST_IDLE));
    tick();
    chk("to_err_pulse", 64'(bus.RSP_ERR),   64'h0);
    slv_mode = 0;

    // simultaneous ARREADY and RVALID in ADDR (ptr now 1)
    slv_fixed      = 1'b1;
    slv_fixed_data = 32'h1234_5678;
    dc0 = data_cycles;
    bus.REQ_VALID = 4'b0010;
    tick();
    chk("sim_grant", 64'(bus.GRANT_ID), 64'h1);
    bus.REQ_VALID = '0;
    tick();
    tick();
    chk("sim_rsp_valid", 64'(bus.RSP_VALID), 64'h2);
    chk("sim_rsp_data",  64'(bus.RSP_DATA),  64'h1234_5678);
    tick();
    chk("sim_single_rsp", 64'(bus.RSP_VALID), 64'h0);
    chk("sim_no_data_state", 64'(data_cycles - dc0), 64'h0);
    slv_fixed = 1'b0;

    // reset while in DATA (ptr now 2 -> grant 0)
    slv_mode = 2;
    bus.REQ_VALID = 4'b0001;
    tick();
    chk("rd_grant", 64'(bus.GRANT_ID), 64'h0);
    bus.REQ_VALID = '0;
    tick();
    tick();
    chk("rd_in_data", 64'(state_dbg),    64'(ST_DATA));
    chk("rd_rready",  64'(bus.M_RREADY), 64'h1);
    chk("rd_busy",    64'(bus.BUSY),     64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_async");
    tick();
    chk("rst_no_rsp", 64'(bus.RSP_VALID), 64'h0);
    tick();
    rst_n    = 1'b1;
    slv_mode = 0;
    set_addr(1, 32'h64);
    set_addr(3, 32'h6C);
    bus.REQ_VALID = 4'b1010;
    tick();
    chk("post_rst_grant", 64'(bus.GRANT_ID),  64'h1);
    chk("post_rst_ready", 64'(bus.REQ_READY), 64'h2);
    bus.REQ_VALID = '0;
    tick();
    tick();
    chk("post_rst_rsp",  64'(bus.RSP_VALID), 64'h2);
    chk("post_rst_data", 64'(bus.RSP_DATA),  64'hA5A5_0064);
    tick();

    chk("no_ready_rsp_overlap", 64'(overlap_cnt), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
